// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx_ctrl
// Brief   : 8N1 serial receive controller with mid-bit sampling, stop-bit
//           check, FWFT byte FIFO (valid/ready), rts flow control and
//           framing-error / overrun pulses.
// Revision: 1.0 - initial release
// ============================================================================
module uart_rx_ctrl #(
  parameter int BIT_CLK    = 87,
  parameter int FIFO_DEPTH = 4,
  parameter int RTS_THRESH = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rxd,
  output logic                          rts,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          frame_err,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int CW = $clog2(BIT_CLK);
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] c_half   = CW'(BIT_CLK / 2 - 1);
  localparam logic [CW-1:0] c_full   = CW'(BIT_CLK - 1);
  localparam logic [AW:0]   c_depth  = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0]   c_thresh = (AW + 1)'(RTS_THRESH);

  localparam logic [2:0] c_idle  = 3'd0;
  localparam logic [2:0] c_start = 3'd1;
  localparam logic [2:0] c_data  = 3'd2;
  localparam logic [2:0] c_stop  = 3'd3;
  localparam logic [2:0] c_break = 3'd4;

  logic          r_sync1, r_sync2;
  logic [2:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bidx;
  logic [7:0]    r_shift;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW:0]   r_wptr, r_rptr;
  logic [7:0]    r_data;
  logic          r_rts, r_ferr, r_ovr;

  logic          w_rxs;
  logic          w_stop_hit, w_push, w_ferr;
  logic [AW:0]   w_level, w_level_nxt, w_wptr_nxt, w_rptr_nxt;
  logic          w_empty, w_full, w_pop, w_wr;
  logic [7:0]    w_head_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rxd;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rxs = r_sync2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= c_idle;
      r_cnt   <= '0;
      r_bidx  <= '0;
      r_shift <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
      case (r_state)
        c_idle: begin
          r_cnt <= '0;
          if (!w_rxs) r_state <= c_start;
        end
        // A start bit still low at its midpoint is real; otherwise a glitch.
        c_start: begin
          if (r_cnt == c_half) begin
            r_cnt   <= '0;
            r_bidx  <= '0;
            r_state <= w_rxs ? c_idle : c_data;
          end
        end
        c_data: begin
          if (r_cnt == c_full) begin
            r_cnt           <= '0;
            r_shift[r_bidx] <= w_rxs;
            r_bidx          <= r_bidx + 1'b1;
            if (r_bidx == 3'd7) r_state <= c_stop;
          end
        end
        c_stop: begin
          if (r_cnt == c_full) begin
            r_cnt   <= '0;
            r_state <= w_rxs ? c_idle : c_break;
          end
        end
        // Held-low line: wait for idle so a break reports only one error.
        c_break: begin
          r_cnt <= '0;
          if (w_rxs) r_state <= c_idle;
        end
        default: begin
          r_state <= c_idle;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign w_stop_hit = (r_state == c_stop) && (r_cnt == c_full);
  assign w_push     = w_stop_hit && w_rxs;
  assign w_ferr     = w_stop_hit && !w_rxs;

  assign w_level     = r_wptr - r_rptr;
  assign w_empty     = (w_level == '0);
  assign w_full      = (w_level == c_depth);
  assign w_pop       = !w_empty && rx_ready;
  assign w_wr        = w_push && (!w_full || w_pop);
  assign w_wptr_nxt  = r_wptr + (AW + 1)'(w_wr);
  assign w_rptr_nxt  = r_rptr + (AW + 1)'(w_pop);
  assign w_level_nxt = w_wptr_nxt - w_rptr_nxt;

  // The new head is the byte being written only when the FIFO drains to it this cycle.
  assign w_head_nxt = (w_wr && (w_rptr_nxt[AW-1:0] == r_wptr[AW-1:0])) ?
                      r_shift : r_mem[w_rptr_nxt[AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= r_shift;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_data <= '0;
      r_rts  <= 1'b1;
      r_ferr <= 1'b0;
      r_ovr  <= 1'b0;
    end else begin
      r_wptr <= w_wptr_nxt;
      r_rptr <= w_rptr_nxt;
      if (w_level_nxt != '0) r_data <= w_head_nxt;
      r_rts  <= (w_level_nxt < c_thresh);
      r_ferr <= w_ferr;
      r_ovr  <= w_push && w_full && !w_pop;
    end
  end

  assign rts        = r_rts;
  assign rx_data    = r_data;
  assign rx_valid   = !w_empty;
  assign frame_err  = r_ferr;
  assign overrun    = r_ovr;
  assign fifo_level = w_level;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// tb_uart_rx_ctrl: directed serial frames checked against a queue-based
// reference model every cycle, plus hand-computed literal expectations.
module tb_uart_rx_ctrl;
  localparam int BC       = 8;
  localparam int DEPTH    = 4;
  localparam int THRESH   = 3;
  // sync (2) + IDLE->START (1) + half bit + 8 data bits + stop bit
  localparam int STOP_LAT = 3 + BC / 2 + 9 * BC;

  logic       clk = 1'b0, reset = 1'b0, rxd = 1'b1, rx_ready = 1'b1;
  logic       rts, rx_valid, frame_err, overrun;
  logic [7:0] rx_data;
  logic [2:0] fifo_level;

  uart_rx_ctrl #(.BIT_CLK(BC), .FIFO_DEPTH(DEPTH), .RTS_THRESH(THRESH)) dut (
    .clk(clk), .reset(reset), .rxd(rxd), .rts(rts), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .frame_err(frame_err),
    .overrun(overrun), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  typedef struct { int at; logic [7:0] b; bit good; } ev_t;
  ev_t        evq[$];
  logic [7:0] mq[$];
  logic [7:0] got[$];
  int         edge_n = 0, checks = 0, failures = 0;
  int         fe_cnt = 0, ov_cnt = 0, vcyc = 0, last_start = 0;
  logic [7:0] m_data = 8'h00;
  bit         m_fe = 1'b0, m_ov = 1'b0;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: frames complete at known edges; FIFO is a plain queue.
  always @(posedge clk) begin
    edge_n++;
    if (!reset) begin
      mq.delete();
      evq.delete();
      m_data = 8'h00;
      m_fe   = 1'b0;
      m_ov   = 1'b0;
    end else begin
      bit  pop;
      ev_t e;
      pop  = (mq.size() > 0) && rx_ready;
      m_fe = 1'b0;
      m_ov = 1'b0;
      if (pop) void'(mq.pop_front());
      if (evq.size() > 0 && evq[0].at == edge_n) begin
        e = evq.pop_front();
        if (!e.good) m_fe = 1'b1;
        else if (mq.size() < DEPTH) mq.push_back(e.b);
        else m_ov = 1'b1;
      end
      if (mq.size() > 0) m_data = mq[0];
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      chk("rx_valid",   int'(rx_valid),   int'(mq.size() > 0));
      chk("rx_data",    int'(rx_data),    int'(m_data));
      chk("fifo_level", int'(fifo_level), mq.size());
      chk("rts",        int'(rts),        int'(mq.size() < THRESH));
      chk("frame_err",  int'(frame_err),  int'(m_fe));
      chk("overrun",    int'(overrun),    int'(m_ov));
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
      if (rx_valid) vcyc++;
      if (rx_valid && rx_ready) got.push_back(rx_data);
    end
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(logic [7:0] b, bit stop);
    @(posedge clk);
    #1;
    last_start = edge_n;
    evq.push_back('{edge_n + STOP_LAT, b, stop});
    rxd = 1'b0;
    tick(BC);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      tick(BC);
    end
    rxd = stop;
    tick(BC);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    tick(4);
    chk("rst_rts",   int'(rts),        1);
    chk("rst_valid", int'(rx_valid),   0);
    chk("rst_data",  int'(rx_data),    0);
    chk("rst_level", int'(fifo_level), 0);
    chk("rst_ferr",  int'(frame_err),  0);
    reset = 1'b1;
    tick(3);

    // 1: single good byte, consumer always ready
    send(8'hA5, 1'b1);
    tick(10);
    chk("t1_count", got.size(), 1);
    chk("t1_byte",  int'(got[0]), 'hA5);
    chk("t1_vcyc",  vcyc, 1);
    chk("t1_level", int'(fifo_level), 0);

    // 2: short glitch on the idle line
    @(posedge clk); #1;
    rxd = 1'b0;
    tick(2);
    rxd = 1'b1;
    tick(20);
    chk("t2_count", got.size(), 1);
    chk("t2_ferr",  fe_cnt, 0);
    chk("t2_vcyc",  vcyc, 1);

    // 3: bad stop bit followed by a long break, then a good byte
    send(8'h3C, 1'b0);
    tick(40);
    rxd = 1'b1;
    tick(12);
    chk("t3_ferr",  fe_cnt, 1);
    chk("t3_level", int'(fifo_level), 0);
    send(8'h81, 1'b1);
    tick(10);
    chk("t3_count", got.size(), 2);
    chk("t3_byte",  int'(got[1]), 'h81);
    chk("t3_ferr2", fe_cnt, 1);

    // 4: consumer stalled, five bytes into a four-deep FIFO
    rx_ready = 1'b0;
    for (int b = 1; b <= 5; b++) begin
      send(8'(b), 1'b1);
      chk("t4_rts", int'(rts), int'(b < 3));
    end
    tick(4);
    chk("t4_ovr",   ov_cnt, 1);
    chk("t4_level", int'(fifo_level), 4);
    chk("t4_count", got.size(), 2);
    rx_ready = 1'b1;
    tick(8);
    chk("t4_drain", got.size(), 6);
    for (int i = 0; i < 4; i++) chk("t4_order", int'(got[2 + i]), i + 1);
    chk("t4_rts_up", int'(rts), 1);

    // 5: full FIFO, pop coincident with the stop sample of 0x77
    rx_ready = 1'b0;
    for (int b = 'h10; b <= 'h13; b++) send(8'(b), 1'b1);
    chk("t5_full", int'(fifo_level), 4);
    fork
      send(8'h77, 1'b1);
      begin
        tick(2);
        while (edge_n < last_start + STOP_LAT - 1) tick(1);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
      end
    join
    tick(3);
    chk("t5_ovr",   ov_cnt, 1);
    chk("t5_level", int'(fifo_level), 4);
    chk("t5_pop",   int'(got[6]), 'h10);
    rx_ready = 1'b1;
    tick(8);
    chk("t5_count", got.size(), 11);
    for (int i = 0; i < 3; i++) chk("t5_order", int'(got[7 + i]), 'h11 + i);
    chk("t5_last", int'(got[10]), 'h77);

    // 6: reset in the middle of a frame
    @(posedge clk); #1;
    rxd = 1'b0;
    tick(BC);
    rxd = 1'b1;
    tick(BC);
    rxd = 1'b0;
    tick(BC / 2 + 1);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_rts",   int'(rts),        1);
    chk("t6_valid", int'(rx_valid),   0);
    chk("t6_data",  int'(rx_data),    0);
    chk("t6_level", int'(fifo_level), 0);
    chk("t6_ferr",  int'(frame_err),  0);
    chk("t6_ovr",   int'(overrun),    0);
    rxd = 1'b1;
    tick(3);
    reset = 1'b1;
    tick(5);
    send(8'h5A, 1'b1);
    tick(10);
    chk("t6_count", got.size(), 12);
    chk("t6_byte",  int'(got[11]), 'h5A);
    chk("t6_ferr2", fe_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
